// File: rtl/pack_if.sv
// pack_if: handshake bundle between a field-set source/word consumer and
// the instr_packer.
//   master: drives field sets (in_valid, fmt, op, func, rs, rt, rd, shamt,
//           imm16, imm26) and out_ready; observes in_ready, out_valid,
//           out_instr, out_addr, level, err.
//   slave:  the packer side (the reverse directions).
// DEPTH must match the packer's DEPTH so that level has the right width.
interface pack_if #(
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [1:0]    fmt;
  logic [5:0]    op;
  logic [5:0]    func;
  logic [4:0]    rs;
  logic [4:0]    rt;
  logic [4:0]    rd;
  logic [4:0]    shamt;
  logic [15:0]   imm16;
  logic [25:0]   imm26;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_instr;
  logic [31:0]   out_addr;
  logic [LW-1:0] level;
  logic          err;

  modport master (
    output in_valid, fmt, op, func, rs, rt, rd, shamt, imm16, imm26, out_ready,
    input  in_ready, out_valid, out_instr, out_addr, level, err
  );

  modport slave (
    input  in_valid, fmt, op, func, rs, rt, rd, shamt, imm16, imm26, out_ready,
    output in_ready, out_valid, out_instr, out_addr, level, err
  );
endinterface

// File: rtl/instr_packer.sv
// instr_packer: packs MIPS opcode/register/immediate fields into 32-bit
// instruction words (R, I or J format), buffers them in a DEPTH-entry FIFO
// and presents each word with the instruction-memory address it belongs at,
// starting at BASE_ADDR and advancing by 4 per word taken.
//
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-high; empties the FIFO and restarts
//           addressing at BASE_ADDR
//   bus   - pack_if.slave: field-set input handshake, packed-word output
//           handshake, occupancy (level) and reserved-format error pulse (err)
//
// Build option: macro PACKER_FMTCHK_EN.
//   defined   - fmt == 3 is consumed without writing a word and err pulses
//               for one cycle after the accepting edge.
//   undefined - fmt == 3 is packed as R format; err is held at 0.
module instr_packer #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_3000
) (
  input logic   clk,
  input logic   reset,
  pack_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  // Build one instruction word from the field set; reserved fmt packs as R.
  function automatic logic [31:0] pack_word(
    input logic [1:0]  fmt,
    input logic [5:0]  op,
    input logic [5:0]  func,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  shamt,
    input logic [15:0] imm16,
    input logic [25:0] imm26
  );
    logic [31:0] word;
    case (fmt)
      2'd1:    word = {op, rs, rt, imm16};
      2'd2:    word = {op, imm26};
      default: word = {op, rs, rt, rd, shamt, func};
    endcase
    return word;
  endfunction

  logic [31:0]   mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [LW-1:0] level_r;
  logic [31:0]   addr_r;

  logic          full_s;
  logic          empty_s;
  logic          accept_s;
  logic          push_s;
  logic          pop_s;
  logic          reserved_s;
  logic [31:0]   word_s;

  // Handshake decode; full/empty come from the registered level only, so
  // in_ready/out_valid never depend combinationally on in_valid/out_ready.
  always_comb begin
    full_s     = (level_r == LW'(DEPTH));
    empty_s    = (level_r == {LW{1'b0}});
    accept_s   = bus.in_valid && !full_s;
    reserved_s = (bus.fmt == 2'd3);
    pop_s      = bus.out_ready && !empty_s;
`ifdef PACKER_FMTCHK_EN
    push_s     = accept_s && !reserved_s;
`else
    push_s     = accept_s;
`endif
    word_s     = pack_word(bus.fmt, bus.op, bus.func, bus.rs, bus.rt, bus.rd,
                           bus.shamt, bus.imm16, bus.imm26);
  end

  // FIFO storage write; entries need no reset because level gates the output.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= word_s;
    end
  end

  // Pointers, occupancy and output address.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      level_r  <= {LW{1'b0}};
      addr_r   <= BASE_ADDR;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
        addr_r   <= addr_r + 32'd4;
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

`ifdef PACKER_FMTCHK_EN
  logic err_r;

  // One-cycle pulse after a reserved-format set is consumed and dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_r <= 1'b0;
    end else begin
      err_r <= accept_s && reserved_s;
    end
  end

  assign bus.err = err_r;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.in_ready  = !full_s;
  assign bus.out_valid = !empty_s;
  assign bus.out_instr = empty_s ? 32'h0000_0000 : mem_r[rd_ptr_r];
  assign bus.out_addr  = addr_r;
  assign bus.level     = level_r;

endmodule

// File: tb/tb_instr_packer.sv
module tb_instr_packer;

  localparam int DEPTH = 4;
  localparam logic [31:0] BASE = 32'h0000_3000;

  logic clk;
  logic reset;

  pack_if #(.DEPTH(DEPTH)) bus();

  instr_packer #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total;
  int passed;

  // Reference model: a queue of words plus the address of the head word.
  logic [31:0] mq [$];
  logic [31:0] exp_addr;
  bit          exp_err;

  function automatic logic [31:0] ref_word(input int fmt, input int op, input int func,
                                           input int rs, input int rt, input int rd,
                                           input int shamt, input int imm16, input int imm26);
    if (fmt == 1)
      return (op << 26) + (rs << 21) + (rt << 16) + imm16;
    else if (fmt == 2)
      return (op << 26) + imm26;
    else
      return (op << 26) + (rs << 21) + (rt << 16) + (rd << 11) + (shamt << 6) + func;
  endfunction

  task automatic set_fields(input int fmt, input int op, input int func, input int rs,
                            input int rt, input int rd, input int shamt, input int imm16,
                            input int imm26);
    bus.fmt = fmt[1:0]; bus.op = op[5:0]; bus.func = func[5:0];
    bus.rs = rs[4:0]; bus.rt = rt[4:0]; bus.rd = rd[4:0]; bus.shamt = shamt[4:0];
    bus.imm16 = imm16[15:0]; bus.imm26 = imm26[25:0];
  endtask

  task automatic rand_fields();
    set_fields($urandom_range(3, 0), $urandom_range(63, 0), $urandom_range(63, 0),
               $urandom_range(31, 0), $urandom_range(31, 0), $urandom_range(31, 0),
               $urandom_range(31, 0), $urandom_range(16'hffff, 0), $urandom & 32'h03ff_ffff);
  endtask

  // One clock: model decides what the edge does from the pre-edge state.
  task automatic tick();
    bit acc, pop;
    logic [31:0] w;
    acc = bus.in_valid && (mq.size() < DEPTH);
    pop = bus.out_ready && (mq.size() > 0);
    w = ref_word(bus.fmt, bus.op, bus.func, bus.rs, bus.rt, bus.rd, bus.shamt,
                 bus.imm16, bus.imm26);
    @(posedge clk);
    #1;
    exp_err = 1'b0;
    if (pop) begin
      void'(mq.pop_front());
      exp_addr = exp_addr + 32'd4;
    end
    if (acc) begin
`ifdef PACKER_FMTCHK_EN
      if (bus.fmt == 2'd3) exp_err = 1'b1;
      else mq.push_back(w);
`else
      mq.push_back(w);
`endif
    end
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    #3;
    reset = 1'b0;
    mq.delete();
    exp_addr = BASE;
    exp_err = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    total++; if (bus.level !== 3'd0) $display("FAIL reset_level: got %0d want 0", bus.level); else passed++;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); else passed++;
    total++; if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); else passed++;
    total++; if (bus.out_instr !== 32'h0) $display("FAIL reset_out_instr: got %h want 0", bus.out_instr); else passed++;
    total++; if (bus.out_addr !== BASE) $display("FAIL reset_out_addr: got %h want %h", bus.out_addr, BASE); else passed++;
    total++; if (bus.err !== 1'b0) $display("FAIL reset_err: got %b want 0", bus.err); else passed++;
  endtask

  task automatic test_r_pack();
    do_reset();
    set_fields(0, 0, 6'h21, 1, 2, 3, 0, 0, 0);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    total++; if (bus.out_valid !== 1'b1) $display("FAIL r_valid: got %b want 1", bus.out_valid); else passed++;
    total++; if (bus.out_instr !== 32'h0022_1821) $display("FAIL r_instr: got %h want 00221821", bus.out_instr); else passed++;
    total++; if (bus.out_addr !== 32'h0000_3000) $display("FAIL r_addr: got %h want 00003000", bus.out_addr); else passed++;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    total++; if (bus.level !== 3'd0) $display("FAIL r_drain_level: got %0d want 0", bus.level); else passed++;
    total++; if (bus.out_addr !== 32'h0000_3004) $display("FAIL r_drain_addr: got %h want 00003004", bus.out_addr); else passed++;
    total++; if (bus.out_instr !== 32'h0) $display("FAIL r_empty_instr: got %h want 0", bus.out_instr); else passed++;
  endtask

  task automatic test_ij_pack();
    do_reset();
    bus.out_ready = 1'b1;
    set_fields(1, 6'h0d, 0, 0, 1, 0, 0, 16'h1234, 0);
    bus.in_valid = 1'b1;
    tick();
    total++; if (bus.out_instr !== 32'h3401_1234) $display("FAIL ori_instr: got %h want 34011234", bus.out_instr); else passed++;
    total++; if (bus.out_addr !== 32'h0000_3000) $display("FAIL ori_addr: got %h want 00003000", bus.out_addr); else passed++;
    set_fields(2, 6'h02, 0, 0, 0, 0, 0, 0, 26'h0000c00);
    tick();
    bus.in_valid = 1'b0;
    total++; if (bus.out_instr !== 32'h0800_0c00) $display("FAIL j_instr: got %h want 08000c00", bus.out_instr); else passed++;
    total++; if (bus.out_addr !== 32'h0000_3004) $display("FAIL j_addr: got %h want 00003004", bus.out_addr); else passed++;
    tick();
    bus.out_ready = 1'b0;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL ij_empty: got %b want 0", bus.out_valid); else passed++;
    total++; if (bus.out_addr !== 32'h0000_3008) $display("FAIL ij_end_addr: got %h want 00003008", bus.out_addr); else passed++;
  endtask

  task automatic test_full();
    logic [31:0] words [5];
    do_reset();
    for (int i = 0; i < 5; i++) begin
      set_fields(i % 3, i + 8, i + 1, i, i + 1, i + 2, i, 16'h1000 + i, 26'h100 + i);
      words[i] = ref_word(i % 3, i + 8, i + 1, i, i + 1, i + 2, i, 16'h1000 + i, 26'h100 + i);
      bus.in_valid = 1'b1;
      tick();
      if (i == 3) begin
        total++; if (bus.in_ready !== 1'b0) $display("FAIL full_in_ready: got %b want 0", bus.in_ready); else passed++;
        total++; if (bus.level !== 3'd4) $display("FAIL full_level: got %0d want 4", bus.level); else passed++;
      end
    end
    bus.in_valid = 1'b0;
    total++; if (bus.level !== 3'd4) $display("FAIL full_5th_dropped: got %0d want 4", bus.level); else passed++;
    // A pop while full must not reopen in_ready for a push on that same edge.
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    total++; if (bus.level !== 3'd3) $display("FAIL full_pop_level: got %0d want 3", bus.level); else passed++;
    for (int i = 1; i < 4; i++) begin
      total++; if (bus.out_instr !== words[i]) $display("FAIL full_order%0d: got %h want %h", i, bus.out_instr, words[i]); else passed++;
      total++; if (bus.out_addr !== BASE + 32'(4 * i)) $display("FAIL full_addr%0d: got %h want %h", i, bus.out_addr, BASE + 32'(4 * i)); else passed++;
      tick();
    end
    bus.out_ready = 1'b0;
    total++; if (bus.level !== 3'd0) $display("FAIL full_drained: got %0d want 0", bus.level); else passed++;
  endtask

  task automatic test_simultaneous();
    logic [31:0] w [3];
    do_reset();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_fields(1, 6'h08 + i, 0, i, i + 4, 0, 0, 16'h0ab0 + i, 0);
      w[i] = ref_word(1, 6'h08 + i, 0, i, i + 4, 0, 0, 16'h0ab0 + i, 0);
      if (i == 2) bus.out_ready = 1'b1;
      tick();
    end
    bus.in_valid = 1'b0;
    total++; if (bus.level !== 3'd2) $display("FAIL simul_level: got %0d want 2", bus.level); else passed++;
    total++; if (bus.out_addr !== BASE + 32'd4) $display("FAIL simul_addr: got %h want %h", bus.out_addr, BASE + 32'd4); else passed++;
    total++; if (bus.out_instr !== w[1]) $display("FAIL simul_head: got %h want %h", bus.out_instr, w[1]); else passed++;
    tick();
    total++; if (bus.out_instr !== w[2]) $display("FAIL simul_next: got %h want %h", bus.out_instr, w[2]); else passed++;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_fields();
      bus.fmt = 2'd1;
      tick();
    end
    bus.in_valid = 1'b0;
    total++; if (bus.level !== 3'd3) $display("FAIL mid_level_pre: got %0d want 3", bus.level); else passed++;
    reset = 1'b1;
    #1;
    total++; if (bus.level !== 3'd0) $display("FAIL mid_level: got %0d want 0", bus.level); else passed++;
    total++; if (bus.out_valid !== 1'b0) $display("FAIL mid_valid: got %b want 0", bus.out_valid); else passed++;
    total++; if (bus.out_addr !== BASE) $display("FAIL mid_addr: got %h want %h", bus.out_addr, BASE); else passed++;
    #1;
    reset = 1'b0;
    mq.delete();
    exp_addr = BASE;
    @(posedge clk);
    #1;
    set_fields(2, 6'h03, 0, 0, 0, 0, 0, 0, 26'h0000040);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    total++; if (bus.out_instr !== 32'h0c00_0040) $display("FAIL mid_next_instr: got %h want 0c000040", bus.out_instr); else passed++;
    total++; if (bus.out_addr !== BASE) $display("FAIL mid_next_addr: got %h want %h", bus.out_addr, BASE); else passed++;
  endtask

  task automatic test_reserved();
    do_reset();
    set_fields(3, 6'h11, 6'h22, 5, 6, 7, 8, 16'hffff, 26'h3ffffff);
    bus.in_valid = 1'b1;
    tick();
    bus.in_valid = 1'b0;
`ifdef PACKER_FMTCHK_EN
    total++; if (bus.err !== 1'b1) $display("FAIL rsv_err: got %b want 1", bus.err); else passed++;
    total++; if (bus.level !== 3'd0) $display("FAIL rsv_level: got %0d want 0", bus.level); else passed++;
    tick();
    total++; if (bus.err !== 1'b0) $display("FAIL rsv_err_pulse: got %b want 0", bus.err); else passed++;
`else
    total++; if (bus.err !== 1'b0) $display("FAIL rsv_err: got %b want 0", bus.err); else passed++;
    total++; if (bus.level !== 3'd1) $display("FAIL rsv_level: got %0d want 1", bus.level); else passed++;
    total++; if (bus.out_instr !== ((32'h11 << 26) | (32'd5 << 21) | (32'd6 << 16) | (32'd7 << 11) | (32'd8 << 6) | 32'h22))
      $display("FAIL rsv_instr: got %h want R-encoded", bus.out_instr); else passed++;
`endif
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      bus.in_valid = ($urandom_range(3, 0) != 0);
      bus.out_ready = ($urandom_range(2, 0) != 0);
      rand_fields();
      tick();
      total++; if (bus.level !== mq.size()) $display("FAIL rnd_level c%0d: got %0d want %0d", c, bus.level, mq.size()); else passed++;
      total++; if (bus.out_valid !== (mq.size() > 0)) $display("FAIL rnd_valid c%0d: got %b", c, bus.out_valid); else passed++;
      total++; if (bus.in_ready !== (mq.size() < DEPTH)) $display("FAIL rnd_in_ready c%0d: got %b", c, bus.in_ready); else passed++;
      total++; if (bus.out_instr !== ((mq.size() > 0) ? mq[0] : 32'h0)) $display("FAIL rnd_instr c%0d: got %h", c, bus.out_instr); else passed++;
      total++; if (bus.out_addr !== exp_addr) $display("FAIL rnd_addr c%0d: got %h want %h", c, bus.out_addr, exp_addr); else passed++;
      total++; if (bus.err !== exp_err) $display("FAIL rnd_err c%0d: got %b want %b", c, bus.err, exp_err); else passed++;
    end
    idle();
  endtask

  initial begin
    total = 0;
    passed = 0;
    exp_addr = BASE;
    exp_err = 1'b0;
    reset = 1'b1;
    idle();
    set_fields(0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    test_reset();
    test_r_pack();
    test_ij_pack();
    test_full();
    test_simultaneous();
    test_reset_mid();
    test_reserved();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/instr_packer.md
# instr_packer

Inverse of the instruction field splitter: packs opcode, register and immediate fields into 32-bit MIPS instruction words according to an instruction format. Each packed word is buffered in a small FIFO and presented with the instruction-memory address it belongs at. It sits between the testbench/loader stimulus source and the IM write port, so programs can be built field-by-field and streamed into instruction memory.

## Interface
- DEPTH, 4: FIFO entries; power of two, at least 2.
- BASE_ADDR, 32'h0000_3000: address of the first word emitted after reset.
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  field set on inputs is valid.
- in_ready  output  1  packer can accept a field set this cycle.
- fmt  input  2  format: 0 = R, 1 = I, 2 = J, 3 = reserved.
- op  input  6  opcode field.
- func  input  6  function field (R only).
- rs, rt, rd  input  5 each  register addresses.
- shamt  input  5  shift amount (R only).
- imm16  input  16  immediate (I only).
- imm26  input  26  jump index (J only).
- out_valid  output  1  FIFO head holds a packed word.
- out_ready  input  1  consumer takes the head this cycle.
- out_instr  output  32  packed word at the FIFO head.
- out_addr  output  32  IM address for out_instr.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy.
- err  output  1  one-cycle pulse when a reserved-format set is dropped (see Configuration).

## Operation
- Encoding:
  - R = {op, rs, rt, rd, shamt, func}.
  - I = {op, rs, rt, imm16}.
  - J = {op, imm26}.
  - Unused inputs for a format are ignored.
- Push: in_valid && in_ready at a clock edge writes the encoded word at the tail; level increments.
- Pop: out_valid && out_ready at a clock edge removes the head; out_addr increments by 4; level decrements.
- Push and pop in the same cycle: level unchanged and both take effect. Legal whenever level is between 1 and DEPTH-1.
- Full (level == DEPTH): in_ready = 0. A simultaneous pop does not reopen in_ready in that same cycle.
- Empty (level == 0): out_valid = 0 and out_instr = 0. out_addr still shows the next address.
- out_addr wraps modulo 2^32. Read and write pointers wrap modulo DEPTH.
- out_instr and out_addr are stable while out_valid && !out_ready.

## Timing
- Reset values:
  - level = 0, out_valid = 0, in_ready = 1.
  - out_instr = 0, out_addr = BASE_ADDR, err = 0.
  - Pointers = 0.
- Reset asserted mid-operation discards all buffered words immediately, with no clock edge required, and restarts addressing at BASE_ADDR.
- Latency: a word accepted at edge N is visible on out_valid/out_instr after edge N if the FIFO was empty. Otherwise it appears in FIFO order.
- Throughput: one push and one pop per cycle.
- in_ready, out_valid and level are derived from registered state only. There is no combinational path from in_valid or out_ready to any output.

## Configuration
- PACKER_FMTCHK_EN defined:
  - fmt == 3 with in_valid && in_ready is consumed (handshake completes) but nothing is written.
  - err pulses high for the one cycle after that edge.
- PACKER_FMTCHK_EN undefined:
  - fmt == 3 is encoded as R format and pushed normally.
  - err is tied to 0.

## Test plan
- R pack: fmt=0, op=0, rs=1, rt=2, rd=3, shamt=0, func=6'h21 pushed into an empty FIFO. Next cycle: out_valid=1, out_instr=32'h0022_1821, out_addr=32'h0000_3000.
- I/J pack with addressing: push ori (fmt=1, op=6'h0d, rs=0, rt=1, imm16=16'h1234) then j (fmt=2, op=6'h02, imm26=26'h0000c00) with out_ready=1.
  - Words out: 32'h3401_1234 at 32'h3000, then 32'h0800_0c00 at 32'h3004.
- Full: hold out_ready=0 and push 5 sets with DEPTH=4.
  - in_ready=0 after the 4th push and level=4.
  - The 5th set is not accepted.
  - Draining yields the first 4 words in order.
- Simultaneous: with level=2, push and pop in the same cycle. level stays 2, out_addr advances by 4, and order is preserved.
- Reset mid-stream: assert reset with level=3. Immediately level=0, out_valid=0, out_addr=32'h3000; the next push is emitted at 32'h3000.
- Reserved format: fmt=3 with PACKER_FMTCHK_EN defined gives err=1 for one cycle and level unchanged. With the macro undefined, the word is R-encoded and level increments.
